regfile_wb_queue: RTL

- Writeback buffer on the producer side of the physical register file write ports.
- Collects completed results (physical tag + data) from N_FU functional units and queues them in order.
- Drives up to N_WAY register-file writes per cycle on wr_idx/wr_data/wr_en, oldest result on lane 0.
- Absorbs bursts wider than the write port count and backpressures the functional units when the queue cannot take a full burst.

---
 rtl/regfile_wb_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order writeback queue feeding the physical register file write lanes

`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG_PR
`define ZERO_REG_PR 0
`endif

module regfile_wb_queue #(
    parameter int N_WAY    = `N_WAY,
    parameter int N_FU     = 4,
    parameter int DEPTH    = 8,
    parameter int CDB_BITS = `CDB_BITS,
    parameter int XLEN     = `XLEN,
    parameter int ZERO_TAG = `ZERO_REG_PR
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N_FU-1:0]                     fu_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]       fu_tag,
    input  logic [N_FU-1:0][XLEN-1:0]           fu_data,
    output logic                                fu_ready,
    output logic [N_WAY-1:0]                    wr_en,
    output logic [N_WAY-1:0][CDB_BITS-1:0]      wr_idx,
    output logic [N_WAY-1:0][XLEN-1:0]          wr_data,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Circular storage; contents need no reset because occupancy alone
    // decides which entries are live.
    logic [CDB_BITS-1:0]          mem_tag_q  [DEPTH];
    logic [XLEN-1:0]              mem_data_q [DEPTH];

    logic [PW-1:0]                head_q, head_d;
    logic [PW-1:0]                tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d;
    logic [N_WAY-1:0]             wr_en_q;
    logic [N_WAY-1:0][CDB_BITS-1:0] wr_idx_q;
    logic [N_WAY-1:0][XLEN-1:0]   wr_data_q;

    logic [CW-1:0]                drain;
    int unsigned                  space;
    int unsigned                  enq_n;
    logic [N_FU-1:0]              enq_ok;
    logic [PW-1:0]                enq_slot [N_FU];
    logic [PW-1:0]                rd_slot  [N_WAY];

    // Pointer advance modulo DEPTH; n never exceeds DEPTH so one wrap suffices.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= 32'(DEPTH)) begin
            s = s - 32'(DEPTH);
        end
        return s[PW-1:0];
    endfunction

    // Drain count and broadcast ready, both from registered occupancy only.
    always_comb begin
        drain = count_q;
        if (32'(count_q) > 32'(N_WAY)) begin
            drain = CW'(N_WAY);
        end
        space    = 32'(DEPTH) - 32'(count_q) + 32'(drain);
        fu_ready = (space >= 32'(N_FU));
    end

    // Compact accepted non-zero-tag results into consecutive tail slots in FU order.
    always_comb begin
        enq_n = 0;
        for (int k = 0; k < N_FU; k++) begin
            enq_ok[k]   = 1'b0;
            enq_slot[k] = ptr_add(tail_q, enq_n);
            if (fu_ready && fu_valid[k] && (fu_tag[k] != CDB_BITS'(ZERO_TAG))) begin
                enq_ok[k] = 1'b1;
                enq_n     = enq_n + 1;
            end
        end
    end

    // Read slots for the drain lanes, oldest entry on lane 0.
    always_comb begin
        for (int l = 0; l < N_WAY; l++) begin
            rd_slot[l] = ptr_add(head_q, 32'(l));
        end
    end

    // Next-state pointers and occupancy.
    always_comb begin
        head_d  = ptr_add(head_q, 32'(drain));
        tail_d  = ptr_add(tail_q, enq_n);
        count_d = count_q - drain + CW'(enq_n);
    end

    // Entry storage write; accepted slots are distinct so writes never collide.
    always_ff @(posedge clock) begin
        for (int k = 0; k < N_FU; k++) begin
            if (enq_ok[k]) begin
                mem_tag_q[enq_slot[k]]  <= fu_tag[k];
                mem_data_q[enq_slot[k]] <= fu_data[k];
            end
        end
    end

    // Pointers, occupancy and registered write lanes; idle lanes keep idx/data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= '0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int l = 0; l < N_WAY; l++) begin
                if (32'(l) < 32'(drain)) begin
                    wr_en_q[l]   <= 1'b1;
                    wr_idx_q[l]  <= mem_tag_q[rd_slot[l]];
                    wr_data_q[l] <= mem_data_q[rd_slot[l]];
                end else begin
                    wr_en_q[l]   <= 1'b0;
                end
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;

endmodule
